adma_as_atx_split_4k: RTL and testbench
=======================================

Name: adma_as_atx_split_4k

Overview:
- Successor to the DMA-transaction-to-AXI-burst fetch stage in the axi_dma address path.
- Accepts one DMA transaction at a time: source address, destination address, and length in beats minus one.
- Splits it into paired AR/AW burst descriptors, one pair per burst.
- Each burst is clipped to the configured words-per-burst, the AXI FIXED 16-beat limit, and a BOUNDARY-byte crossing on either address. It is byte-address aware via DATA_W and supports abort.

Parameters:
SRC_ADDR_W, 32, source address width
DST_ADDR_W, 32, destination address width
DMA_LENGTH_W, 16, transaction length width (beats-1)
MST_ID_W, 5, AXI ID width
ATX_LEN_W, 8, AXI len width (beats-1)
DATA_W, 32, data bus width in bits; BYTES=DATA_W/8 bytes per beat (power of 2)
BOUNDARY, 4096, address boundary in bytes that no burst may cross (power of 2, >= BYTES*2^ATX_LEN_W not required)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tx_src_addr  in  SRC_ADDR_W  transaction source byte address
tx_dst_addr  in  DST_ADDR_W  transaction destination byte address
tx_len  in  DMA_LENGTH_W  beats-1
tx_vld  in  1  transaction valid
tx_rdy  out  1  transaction ready
tx_abort  in  1  abort current transaction (level, sampled each cycle)
atx_id  in  MST_ID_W  AXI ID (CSR)
atx_src_burst  in  2  source burst type, 00 FIXED / 01 INCR
atx_dst_burst  in  2  destination burst type
atx_wd_per_burst  in  ATX_LEN_W  max beats-1 per burst (CSR)
arid, araddr, arlen, arburst  out  MST_ID_W/SRC_ADDR_W/ATX_LEN_W/2  read descriptor
awid, awaddr, awlen, awburst  out  MST_ID_W/DST_ADDR_W/ATX_LEN_W/2  write descriptor
atx_vld  out  1  descriptor pair valid
atx_rdy  in  1  descriptor pair accepted
atx_start  out  1  pulse on descriptor handshake
atx_start_last  out  1  pulse on final descriptor of a transaction
busy  out  1  transaction in progress

Behaviour:
- Reset (async, rst_n=0): state IDLE, tx_rdy=1, atx_vld=0, atx_start=0, atx_start_last=0, busy=0, all descriptor registers 0, abort flag cleared.
- Reset mid-transaction discards all progress; no partial descriptor survives.
- FSM IDLE:
  - tx_rdy=1.
  - On tx_vld&tx_rdy: latch addresses with low log2(BYTES) bits forced to 0, remaining beats = tx_len+1, and a snapshot of atx_id/bursts/wd_per_burst.
  - Go to CALC. CSR changes after this point have no effect on the transaction.
- FSM CALC (1 cycle):
  - Register burst beats B = min(rem, wd+1, capS, capD, bndS, bndD).
  - capX = 16 if X is FIXED, else infinite.
  - bndX = (BOUNDARY - (addrX mod BOUNDARY))/BYTES if X is INCR, else infinite. The FIXED address never moves.
  - Compute widths to DMA_LENGTH_W+1 bits with no overflow. B >= 1 always.
  - If tx_abort is high here: go to IDLE, with no descriptor and no start_last.
  - Otherwise go to ISSUE.
- FSM ISSUE:
  - atx_vld=1; arlen=awlen=B-1, arid=awid=atx_id snapshot, bursts from snapshot.
  - All outputs stay stable until atx_rdy. atx_vld is never withdrawn.
  - tx_abort seen in ISSUE sets the abort flag.
  - On handshake: atx_start=1 for that cycle. atx_start_last=1 if rem==B or the abort flag is set.
  - In the same handshake: rem-=B, and each INCR address += B*BYTES.
  - Then go to IDLE (last/abort, clear the flag) or to CALC.
- atx_start and atx_start_last are combinational from atx_vld&atx_rdy&state. atx_start_last is never high without atx_start.
- busy=1 in CALC/ISSUE.
- Throughput is one descriptor per 2 cycles minimum. The first atx_vld appears 2 cycles after tx handshake.
- tx_len=0 produces a single 1-beat burst with start_last set.
- Address wrap past 2^ADDR_W wraps modulo; the boundary rule already prevents crossing inside a burst.

Test Plan:
- DATA_W=32, INCR/INCR, wd=3, src=0x1000, dst=0x2000, len=9 -> three pairs:
  - arlen/awlen 3 @0x1000/0x2000
  - 3 @0x1010/0x2010
  - 1 @0x1020/0x2020
  - start_last only on the third pair.
- 4K crossing: src=0x0FF8, dst=0x3000, len=7, wd=255 -> arlen 1 @0x0FF8/0x3000, then arlen 5 @0x1000/0x3008, last.
- FIXED src 0x500, INCR dst 0x0, wd=255, len=39 -> arlen 15,15,7; araddr 0x500 constant; awaddr 0x0, 0x40, 0x80.
- Backpressure: hold atx_rdy=0 10 cycles in ISSUE -> all descriptor outputs constant, atx_start=0. A single start pulse follows on release. A CSR change mid-transaction has no effect.
- Abort: raise tx_abort during first ISSUE of the case-1 transaction -> that pair handshakes with start_last=1, returns to IDLE, tx_rdy=1, no further descriptors.
- Reset mid-transaction: rst_n low during second ISSUE -> atx_vld=0 immediately (async). After release, a new len=0 transaction issues a single arlen 0 with start_last.

Source files
------------

// File: rtl/adma_as_atx_split_4k_if.sv
// Handshake and descriptor bundle between the DMA transaction source, the
// 4K-aware burst splitter and the AXI AR/AW issue logic.
interface adma_as_atx_split_4k_if #(
  parameter int SRC_ADDR_W   = 32,
  parameter int DST_ADDR_W   = 32,
  parameter int DMA_LENGTH_W = 16,
  parameter int MST_ID_W     = 5,
  parameter int ATX_LEN_W    = 8
);
  logic [SRC_ADDR_W-1:0]   tx_src_addr;
  logic [DST_ADDR_W-1:0]   tx_dst_addr;
  logic [DMA_LENGTH_W-1:0] tx_len;
  logic                    tx_vld;
  logic                    tx_rdy;
  logic                    tx_abort;
  logic [MST_ID_W-1:0]     atx_id;
  logic [1:0]              atx_src_burst;
  logic [1:0]              atx_dst_burst;
  logic [ATX_LEN_W-1:0]    atx_wd_per_burst;
  logic [MST_ID_W-1:0]     arid;
  logic [SRC_ADDR_W-1:0]   araddr;
  logic [ATX_LEN_W-1:0]    arlen;
  logic [1:0]              arburst;
  logic [MST_ID_W-1:0]     awid;
  logic [DST_ADDR_W-1:0]   awaddr;
  logic [ATX_LEN_W-1:0]    awlen;
  logic [1:0]              awburst;
  logic                    atx_vld;
  logic                    atx_rdy;
  logic                    atx_start;
  logic                    atx_start_last;
  logic                    busy;

  modport slave (
    input  tx_src_addr, tx_dst_addr, tx_len, tx_vld, tx_abort,
    input  atx_id, atx_src_burst, atx_dst_burst, atx_wd_per_burst, atx_rdy,
    output tx_rdy, arid, araddr, arlen, arburst, awid, awaddr, awlen, awburst,
    output atx_vld, atx_start, atx_start_last, busy
  );

  modport master (
    output tx_src_addr, tx_dst_addr, tx_len, tx_vld, tx_abort,
    output atx_id, atx_src_burst, atx_dst_burst, atx_wd_per_burst, atx_rdy,
    input  tx_rdy, arid, araddr, arlen, arburst, awid, awaddr, awlen, awburst,
    input  atx_vld, atx_start, atx_start_last, busy
  );
endinterface

// File: rtl/adma_as_atx_split_4k.sv
// Splits one DMA transaction into paired AR/AW burst descriptors, clipping each
// burst to the CSR burst size, the FIXED 16-beat limit and BOUNDARY crossings.
module adma_as_atx_split_4k #(
  parameter int SRC_ADDR_W   = 32,
  parameter int DST_ADDR_W   = 32,
  parameter int DMA_LENGTH_W = 16,
  parameter int MST_ID_W     = 5,
  parameter int ATX_LEN_W    = 8,
  parameter int DATA_W       = 32,
  parameter int BOUNDARY     = 4096
) (
  input logic                  clk,
  input logic                  rst_n,
  adma_as_atx_split_4k_if.slave bus
);
  localparam int BYTES      = DATA_W / 8;
  localparam int BYTES_LOG2 = $clog2(BYTES);
  localparam int BND_LOG2   = $clog2(BOUNDARY);
  localparam int BND_BEATS  = BOUNDARY / BYTES;
  localparam int CW0        = (DMA_LENGTH_W > ATX_LEN_W) ? DMA_LENGTH_W : ATX_LEN_W;
  localparam int CW1        = (CW0 > (BND_LOG2 - BYTES_LOG2)) ? CW0 : (BND_LOG2 - BYTES_LOG2);
  // One spare bit so rem = len+1 and the full boundary span never overflow.
  localparam int CW         = CW1 + 1;

  localparam logic [CW-1:0]         INF       = {CW{1'b1}};
  localparam logic [CW-1:0]         CAP_FIXED = CW'(5'd16);
  localparam logic [CW-1:0]         ONE       = CW'(1'b1);
  localparam logic [1:0]            BURST_FIXED = 2'b00;
  localparam logic [1:0]            BURST_INCR  = 2'b01;
  localparam logic [SRC_ADDR_W-1:0] SRC_MASK  = ~SRC_ADDR_W'(BYTES - 1);
  localparam logic [DST_ADDR_W-1:0] DST_MASK  = ~DST_ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SRC_ADDR_W-1:0] r_src;
  logic [DST_ADDR_W-1:0] r_dst;
  logic [CW-1:0]         r_rem;
  logic [CW-1:0]         r_beats;
  logic [ATX_LEN_W-1:0]  r_len;
  logic [MST_ID_W-1:0]   r_id;
  logic [1:0]            r_src_burst;
  logic [1:0]            r_dst_burst;
  logic [ATX_LEN_W-1:0]  r_wd;
  logic                  r_abort;
  logic                  w_hs;
  logic                  w_last;
  logic [CW-1:0]         w_cap_s;
  logic [CW-1:0]         w_cap_d;
  logic [CW-1:0]         w_bnd_s;
  logic [CW-1:0]         w_bnd_d;
  logic [CW-1:0]         w_beats;
  logic                  w_src_incr;
  logic                  w_dst_incr;

  function automatic logic [CW-1:0] min2(input logic [CW-1:0] a, input logic [CW-1:0] b);
    min2 = (a < b) ? a : b;
  endfunction

  assign w_src_incr = (r_src_burst == BURST_INCR);
  assign w_dst_incr = (r_dst_burst == BURST_INCR);

  // Per-burst beat limits from the latched addresses and burst types.
  always_comb begin
    w_cap_s = INF;
    w_cap_d = INF;
    w_bnd_s = INF;
    w_bnd_d = INF;
    if (r_src_burst == BURST_FIXED) begin
      w_cap_s = CAP_FIXED;
    end else begin
      w_cap_s = INF;
    end
    if (r_dst_burst == BURST_FIXED) begin
      w_cap_d = CAP_FIXED;
    end else begin
      w_cap_d = INF;
    end
    if (w_src_incr) begin
      w_bnd_s = CW'(BND_BEATS) - CW'(r_src[BND_LOG2-1:BYTES_LOG2]);
    end else begin
      w_bnd_s = INF;
    end
    if (w_dst_incr) begin
      w_bnd_d = CW'(BND_BEATS) - CW'(r_dst[BND_LOG2-1:BYTES_LOG2]);
    end else begin
      w_bnd_d = INF;
    end
    w_beats = min2(min2(min2(r_rem, CW'(r_wd) + ONE), min2(w_cap_s, w_cap_d)),
                   min2(w_bnd_s, w_bnd_d));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and descriptor handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.tx_vld) begin
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (bus.tx_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.atx_rdy) begin
          w_hs   = 1'b1;
          // An abort raised in the handshake cycle itself also ends the transaction.
          w_last = (r_rem == r_beats) || r_abort || bus.tx_abort;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_CALC;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transaction snapshot, burst sizing and address/remaining-beat advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_rem       <= '0;
      r_beats     <= '0;
      r_len       <= '0;
      r_id        <= '0;
      r_src_burst <= 2'b00;
      r_dst_burst <= 2'b00;
      r_wd        <= '0;
      r_abort     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_abort <= 1'b0;
          if (bus.tx_vld) begin
            r_src       <= bus.tx_src_addr & SRC_MASK;
            r_dst       <= bus.tx_dst_addr & DST_MASK;
            r_rem       <= CW'(bus.tx_len) + ONE;
            r_id        <= bus.atx_id;
            r_src_burst <= bus.atx_src_burst;
            r_dst_burst <= bus.atx_dst_burst;
            r_wd        <= bus.atx_wd_per_burst;
          end
        end
        ST_CALC: begin
          r_beats <= w_beats;
          r_len   <= ATX_LEN_W'(w_beats - ONE);
        end
        ST_ISSUE: begin
          if (bus.atx_rdy) begin
            r_abort <= 1'b0;
            r_rem   <= r_rem - r_beats;
            if (w_src_incr) begin
              r_src <= r_src + (SRC_ADDR_W'(r_beats) << BYTES_LOG2);
            end
            if (w_dst_incr) begin
              r_dst <= r_dst + (DST_ADDR_W'(r_beats) << BYTES_LOG2);
            end
          end else if (bus.tx_abort) begin
            r_abort <= 1'b1;
          end
        end
        default: begin
          r_abort <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_rdy         = (r_state == ST_IDLE);
  assign bus.busy           = (r_state == ST_CALC) || (r_state == ST_ISSUE);
  assign bus.atx_vld        = (r_state == ST_ISSUE);
  assign bus.atx_start      = w_hs;
  assign bus.atx_start_last = w_hs & w_last;
  assign bus.arid           = r_id;
  assign bus.awid           = r_id;
  assign bus.araddr         = r_src;
  assign bus.awaddr         = r_dst;
  assign bus.arlen          = r_len;
  assign bus.awlen          = r_len;
  assign bus.arburst        = r_src_burst;
  assign bus.awburst        = r_dst_burst;
endmodule

// File: tb/tb_adma_as_atx_split_4k.sv
// Directed scoreboard bench for the 4K-aware AR/AW burst splitter.
module tb_adma_as_atx_split_4k;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  adma_as_atx_split_4k_if bus ();

  adma_as_atx_split_4k dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ar;
    logic [31:0] aw;
    logic [7:0]  len;
    logic [4:0]  id;
    logic [1:0]  sb;
    logic [1:0]  db;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int errors   = 0;
  int n_starts = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] ar, input logic [31:0] aw, input logic [7:0] len,
                      input logic [4:0] id, input logic [1:0] sbt, input logic [1:0] dbt,
                      input logic last);
    exp_t e;
    e.ar = ar; e.aw = aw; e.len = len; e.id = id; e.sb = sbt; e.db = dbt; e.last = last;
    sb_q.push_back(e);
  endtask

  task automatic set_csr(input logic [4:0] id, input logic [1:0] sbt, input logic [1:0] dbt,
                         input logic [7:0] wd);
    bus.atx_id = id; bus.atx_src_burst = sbt; bus.atx_dst_burst = dbt; bus.atx_wd_per_burst = wd;
  endtask

  task automatic send_tx(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    chk("tx_rdy_before_send", bus.tx_rdy, 1);
    bus.tx_src_addr = s; bus.tx_dst_addr = d; bus.tx_len = l; bus.tx_vld = 1'b1;
    @(posedge clk); #1;
    bus.tx_vld = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int k = 0;
    while (k < 20 && !bus.atx_vld) begin @(posedge clk); #1; k++; end
    chk({tag, "_vld_wait"}, bus.atx_vld, 1);
  endtask

  task automatic wait_idle(input string tag, input int exp_starts);
    int k = 0;
    while (k < 300 && !(sb_q.size() == 0 && bus.tx_rdy && !bus.atx_vld)) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, "_drained"}, (sb_q.size() == 0) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_starts"}, n_starts, exp_starts);
    chk({tag, "_idle_rdy"}, bus.tx_rdy, 1);
    n_starts = 0;
  endtask

  // Scoreboard consumer: every descriptor handshake must match the next expected pair.
  always @(negedge clk) begin
    exp_t e;
    if (bus.atx_start) n_starts++;
    if (rst_n && bus.atx_vld && bus.atx_rdy) begin
      chk("desc_expected", (sb_q.size() != 0) ? 1 : 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("araddr", bus.araddr, e.ar);
        chk("awaddr", bus.awaddr, e.aw);
        chk("arlen", bus.arlen, e.len);
        chk("awlen", bus.awlen, e.len);
        chk("arid", bus.arid, e.id);
        chk("awid", bus.awid, e.id);
        chk("arburst", bus.arburst, e.sb);
        chk("awburst", bus.awburst, e.db);
        chk("atx_start", bus.atx_start, 1);
        chk("atx_start_last", bus.atx_start_last, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_src_addr = 32'h0; bus.tx_dst_addr = 32'h0; bus.tx_len = 16'h0;
    bus.tx_vld = 1'b0; bus.tx_abort = 1'b0; bus.atx_rdy = 1'b0;
    set_csr(5'h03, 2'b01, 2'b01, 8'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_rdy", bus.tx_rdy, 1);
    chk("rst_atx_vld", bus.atx_vld, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.atx_start, 0);
    chk("rst_start_last", bus.atx_start_last, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_arlen", bus.arlen, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR/INCR, 4-beat bursts, 10 beats total.
    bus.atx_rdy = 1'b1;
    push(32'h1000, 32'h2000, 8'd3, 5'h03, 2'b01, 2'b01, 1'b0);
    push(32'h1010, 32'h2010, 8'd3, 5'h03, 2'b01, 2'b01, 1'b0);
    push(32'h1020, 32'h2020, 8'd1, 5'h03, 2'b01, 2'b01, 1'b1);
    send_tx(32'h1000, 32'h2000, 16'd9);
    chk("calc_busy", bus.busy, 1);
    chk("calc_tx_rdy", bus.tx_rdy, 0);
    chk("calc_vld", bus.atx_vld, 0);
    @(posedge clk); #1;
    chk("first_vld_latency", bus.atx_vld, 1);
    wait_idle("t1", 3);

    // Source crosses a 4 KiB boundary after two beats.
    set_csr(5'h0A, 2'b01, 2'b01, 8'd255);
    push(32'h0FF8, 32'h3000, 8'd1, 5'h0A, 2'b01, 2'b01, 1'b0);
    push(32'h1000, 32'h3008, 8'd5, 5'h0A, 2'b01, 2'b01, 1'b1);
    send_tx(32'h0FF8, 32'h3000, 16'd7);
    wait_idle("t2", 2);

    // FIXED source is capped at 16 beats and never moves.
    set_csr(5'h11, 2'b00, 2'b01, 8'd255);
    push(32'h0500, 32'h0000, 8'd15, 5'h11, 2'b00, 2'b01, 1'b0);
    push(32'h0500, 32'h0040, 8'd15, 5'h11, 2'b00, 2'b01, 1'b0);
    push(32'h0500, 32'h0080, 8'd7, 5'h11, 2'b00, 2'b01, 1'b1);
    send_tx(32'h0500, 32'h0000, 16'd39);
    wait_idle("t3", 3);

    // Backpressure with a CSR change while the transaction is in flight.
    bus.atx_rdy = 1'b0;
    set_csr(5'h07, 2'b01, 2'b01, 8'd3);
    push(32'h4000, 32'h5000, 8'd3, 5'h07, 2'b01, 2'b01, 1'b0);
    push(32'h4010, 32'h5010, 8'd1, 5'h07, 2'b01, 2'b01, 1'b1);
    send_tx(32'h4000, 32'h5000, 16'd5);
    wait_vld("t4");
    for (int k = 0; k < 10; k++) begin
      if (k == 3) set_csr(5'h1F, 2'b00, 2'b00, 8'd0);
      chk("bp_vld", bus.atx_vld, 1);
      chk("bp_start", bus.atx_start, 0);
      chk("bp_araddr", bus.araddr, 32'h4000);
      chk("bp_awaddr", bus.awaddr, 32'h5000);
      chk("bp_arlen", bus.arlen, 8'd3);
      chk("bp_arid", bus.arid, 5'h07);
      @(posedge clk); #1;
    end
    bus.atx_rdy = 1'b1;
    wait_idle("t4", 2);

    // Abort during the first ISSUE ends the transaction on that pair.
    set_csr(5'h03, 2'b01, 2'b01, 8'd3);
    bus.atx_rdy = 1'b0;
    push(32'h1000, 32'h2000, 8'd3, 5'h03, 2'b01, 2'b01, 1'b1);
    send_tx(32'h1000, 32'h2000, 16'd9);
    wait_vld("t5");
    bus.tx_abort = 1'b1;
    @(posedge clk); #1;
    bus.atx_rdy = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx_rdy", bus.tx_rdy, 1);
    chk("abort_busy", bus.busy, 0);
    bus.tx_abort = 1'b0;
    wait_idle("t5", 1);

    // Reset in the second ISSUE discards the transaction.
    bus.atx_rdy = 1'b0;
    push(32'h1000, 32'h2000, 8'd3, 5'h03, 2'b01, 2'b01, 1'b0);
    send_tx(32'h1000, 32'h2000, 16'd9);
    wait_vld("t6");
    bus.atx_rdy = 1'b1;
    @(posedge clk); #1;
    bus.atx_rdy = 1'b0;
    @(posedge clk); #1;
    chk("second_issue_vld", bus.atx_vld, 1);
    chk("second_issue_araddr", bus.araddr, 32'h1010);
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", bus.atx_vld, 0);
    chk("async_rst_tx_rdy", bus.tx_rdy, 1);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_araddr", bus.araddr, 0);
    chk("async_rst_arlen", bus.arlen, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.atx_rdy = 1'b1;
    wait_idle("t6", 1);

    // Single-beat transaction with unaligned addresses.
    push(32'h7004, 32'h8008, 8'd0, 5'h03, 2'b01, 2'b01, 1'b1);
    send_tx(32'h7006, 32'h800B, 16'd0);
    wait_idle("t7", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
